// File: rtl/uart_host_bridge.sv
// uart_host_bridge
//   Memory-mapped host controller for the uart core. CPU writes to DATA go into a
//   TX FIFO that a small FSM feeds to the core via the uart_we / uart_data_in
//   handshake; bytes arriving on uart_rx_done are queued in an RX FIFO and popped
//   by DATA reads.
//
//   Register map (bus_addr):
//     0 DATA    W: push TX byte   R: pop RX byte (0 when empty)
//     1 STATUS  [0]tx_empty [1]tx_full [2]rx_empty [3]rx_full [4]RXOVR(W1C)
//               [5]TXOVR(W1C) [6]tx_active [15:8]rx_count [23:16]tx_count
//     2 CTRL    [0]EN [1]RXIE [2]TXIE
//     3 reserved, reads 0
//
//   Ports: clk, rst_n (async, active-low); bus_cs/bus_we/bus_addr/bus_wdata/bus_rdata
//   (CPU side, rdata registered); uart_we/uart_en/uart_data_in/uart_data_out/
//   uart_tx_busy/uart_tx_done/uart_rx_done (core side); irq (registered).
//
//   Build option: define UART_HOST_BRIDGE_IRQ_EN to enable the interrupt logic and
//   the RXIE/TXIE control bits. Otherwise irq is tied low and CTRL[2:1] read 0.
module uart_host_bridge #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_cs,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        uart_we,
  output logic        uart_en,
  output logic [7:0]  uart_data_in,
  input  logic [7:0]  uart_data_out,
  input  logic        uart_tx_busy,
  input  logic        uart_tx_done,
  input  logic        uart_rx_done,
  output logic        irq
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_FULL_CNT = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0] RX_FULL_CNT = (RAW+1)'(RX_DEPTH);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} tx_state_t;

  // ---------------------------------------------------------------- bus decode
  logic wr_acc, rd_acc;
  assign wr_acc = bus_cs &  bus_we;
  assign rd_acc = bus_cs & ~bus_we;

  // Only low bits of the write bus matter; fold the rest so they are accounted for.
  logic unused_wdata;
  assign unused_wdata = ^bus_wdata;

  // ---------------------------------------------------------------- control
  logic ctrl_en, ctrl_rxie, ctrl_txie;
  logic rxovr, txovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_en <= 1'b0;
    else if (wr_acc && bus_addr == A_CTRL) ctrl_en <= bus_wdata[0];
  end

`ifdef UART_HOST_BRIDGE_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_rxie <= 1'b0;
      ctrl_txie <= 1'b0;
    end else if (wr_acc && bus_addr == A_CTRL) begin
      ctrl_rxie <= bus_wdata[1];
      ctrl_txie <= bus_wdata[2];
    end
  end
`else
  assign ctrl_rxie = 1'b0;
  assign ctrl_txie = 1'b0;
`endif

  assign uart_en = ctrl_en;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [TAW:0]   tx_cnt;
  logic           tx_empty, tx_full, tx_pop, tx_push_req, tx_push, tx_ovr_set;

  assign tx_empty    = (tx_cnt == '0);
  assign tx_full     = (tx_cnt == TX_FULL_CNT);
  assign tx_push_req = wr_acc && bus_addr == A_DATA;
  // A same-cycle pop frees a slot first, so a full FIFO still accepts the push.
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovr_set  = tx_push_req &   tx_full & ~tx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TAW'(1);
      if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
      tx_cnt <= tx_cnt + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
    end
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_t st, st_nxt;
  logic [7:0] tx_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    tx_pop = 1'b0;
    case (st)
      S_IDLE:  if (ctrl_en && !tx_empty && !uart_tx_busy) begin
                 tx_pop = 1'b1;
                 st_nxt = S_REQ;
               end
      S_REQ:   if (uart_tx_busy) st_nxt = S_WAIT;
      S_WAIT:  if (uart_tx_done) st_nxt = S_DRAIN;
      S_DRAIN: if (!uart_tx_busy) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tx_hold <= 8'h00;
    else if (tx_pop) tx_hold <= tx_mem[tx_rp];
  end

  // Decoded straight from state so an async reset drops the request at once.
  // A held byte parks in REQ with the request masked while EN is clear.
  assign uart_we      = (st == S_REQ) & ctrl_en;
  assign uart_data_in = tx_hold;

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [RAW:0]   rx_cnt;
  logic           rx_empty, rx_full, rx_pop, rx_push, rx_ovr_set;

  assign rx_empty   = (rx_cnt == '0);
  assign rx_full    = (rx_cnt == RX_FULL_CNT);
  assign rx_pop     = rd_acc && bus_addr == A_DATA && !rx_empty;
  assign rx_push    = uart_rx_done & (~rx_full | rx_pop);
  assign rx_ovr_set = uart_rx_done &   rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= uart_data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RAW'(1);
      if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
      rx_cnt <= rx_cnt + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
    end
  end

  // ---------------------------------------------------------------- sticky flags
  // Set wins over a same-cycle W1C so no overflow event is ever lost.
  logic w1c;
  assign w1c = wr_acc && bus_addr == A_STAT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxovr <= 1'b0;
      txovr <= 1'b0;
    end else begin
      rxovr <= rx_ovr_set | (rxovr & ~(w1c & bus_wdata[4]));
      txovr <= tx_ovr_set | (txovr & ~(w1c & bus_wdata[5]));
    end
  end

  // ---------------------------------------------------------------- read path
  logic [31:0] status, rdata_nxt;

  assign status = {8'h00, 8'(tx_cnt), 8'(rx_cnt), 1'b0, (st != S_IDLE),
                   txovr, rxovr, rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    rdata_nxt = 32'h0;
    case (bus_addr)
      A_DATA:  rdata_nxt = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp]};
      A_STAT:  rdata_nxt = status;
      A_CTRL:  rdata_nxt = {29'h0, ctrl_txie, ctrl_rxie, ctrl_en};
      default: rdata_nxt = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bus_rdata <= 32'h0;
    else if (rd_acc) bus_rdata <= rdata_nxt;
  end

  // ---------------------------------------------------------------- interrupt
`ifdef UART_HOST_BRIDGE_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= (ctrl_rxie & ~rx_empty) |
                       (ctrl_txie & tx_empty & (st == S_IDLE)) | rxovr;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_host_bridge.sv
// tb_uart_host_bridge
//   Drives uart_host_bridge from a CPU-style bus and a behavioural uart core model.
//   Expected values come from queue-based FIFO models kept here.
module tb_uart_host_bridge;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_cs = 1'b0, bus_we = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        uart_we, uart_en, irq;
  logic [7:0]  uart_data_in;
  logic [7:0]  uart_data_out = 8'h0;
  logic        uart_tx_busy, uart_tx_done;
  logic        uart_rx_done = 1'b0;

  uart_host_bridge #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .uart_we(uart_we), .uart_en(uart_en), .uart_data_in(uart_data_in),
    .uart_data_out(uart_data_out), .uart_tx_busy(uart_tx_busy),
    .uart_tx_done(uart_tx_done), .uart_rx_done(uart_rx_done), .irq(irq)
  );

  always #5 clk = ~clk;

`ifdef UART_HOST_BRIDGE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ------------------------------------------------------------ reference model
  logic [7:0] rxq[$];
  logic [7:0] exp_tx[$];
  logic [7:0] sent_q[$];
  bit         m_rxovr = 1'b0, m_txovr = 1'b0;
  int         cmp_idx = 0;

  function automatic logic [31:0] m_status(input logic [31:0] tx_bits);
    logic [7:0] c;
    c = 8'(rxq.size());
    return tx_bits | {16'h0, c, 2'b00, m_txovr, m_rxovr,
                      (rxq.size() == DEPTH), (rxq.size() == 0), 2'b00};
  endfunction

  // ------------------------------------------------------------ uart core model
  bit core_on = 1'b1;
  bit rand_busy = 1'b0;
  int we_busy_viol = 0;

  initial begin
    uart_tx_busy = 1'b0;
    uart_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (core_on && uart_we && !uart_tx_busy) begin
        int blen;
        blen = rand_busy ? int'($urandom_range(1, 12)) : 10;
        sent_q.push_back(uart_data_in);
        uart_tx_busy = 1'b1;
        repeat (blen) @(negedge clk);
        uart_tx_done = 1'b1;
        @(negedge clk);
        uart_tx_done = 1'b0;
        @(negedge clk);
        uart_tx_busy = 1'b0;
      end
    end
  end

  // A transmit request must never overlap a frame in progress.
  always @(posedge clk) begin
    #1;
    if (uart_we && uart_tx_busy) we_busy_viol++;
  end

  // ------------------------------------------------------------ bus tasks
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_cs = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_cs = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_cs = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_cs = 1'b0;
    d = bus_rdata;
  endtask

  task automatic data_write(input logic [7:0] d, input bit accept);
    bus_wr(2'd0, {24'hABCDEF, d});
    if (accept) exp_tx.push_back(d);
    else        m_txovr = 1'b1;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(negedge clk);
    uart_rx_done = 1'b1; uart_data_out = d;
    @(negedge clk);
    uart_rx_done = 1'b0;
    if (rxq.size() < DEPTH) rxq.push_back(d);
    else                    m_rxovr = 1'b1;
  endtask

  task automatic data_read_check(input string tag);
    logic [31:0] r, e;
    bus_rd(2'd0, r);
    e = (rxq.size() > 0) ? {24'h0, rxq.pop_front()} : 32'h0;
    check(tag, r, e);
  endtask

  task automatic status_check(input string tag, input logic [31:0] mask,
                              input logic [31:0] tx_bits);
    logic [31:0] r;
    bus_rd(2'd1, r);
    check(tag, r & mask, m_status(tx_bits) & mask);
  endtask

  task automatic drain_tx(input string tag);
    int t;
    t = 0;
    while ((sent_q.size() < exp_tx.size() || uart_tx_busy) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_sent_count"}, 32'(sent_q.size()), 32'(exp_tx.size()));
    for (int i = cmp_idx; i < exp_tx.size() && i < sent_q.size(); i++)
      check({tag, "_byte"}, 32'(sent_q[i]), 32'(exp_tx[i]));
    cmp_idx = exp_tx.size();
  endtask

  // ------------------------------------------------------------ main sequence
  initial begin
    logic [31:0] r;
    int t;

    repeat (3) @(negedge clk);
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_we", 32'(uart_we), 32'h0);
    check("rst_en", 32'(uart_en), 32'h0);
    check("rst_data_in", 32'(uart_data_in), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    status_check("rst_status", 32'hFFFF_FFFF, 32'h1);
    check("rst_status_const", m_status(32'h1), 32'h5);
    bus_rd(2'd2, r);
    check("rst_ctrl", r, 32'h0);

    // Two back-to-back bytes through a core that stays busy 10 cycles.
    bus_wr(2'd2, 32'h1);
    check("ctrl_en_pin", 32'(uart_en), 32'h1);
    data_write(8'h55, 1'b1);
    data_write(8'hA3, 1'b1);
    drain_tx("tx_pair");
    status_check("tx_pair_status", 32'hFFFF_FFFF, 32'h1);

    // Single received byte.
    rx_pulse(8'h3C);
    status_check("rx1_count", 32'h0000_FF00, 32'h0);
    check("rx1_count_const", m_status(32'h0) & 32'hFF00, 32'h0100);
    data_read_check("rx1_data");
    status_check("rx1_empty", 32'hFFFF_FFFF, 32'h1);
    data_read_check("rx_empty_read");

    // Overflow the RX FIFO, then clear RXOVR.
    for (int i = 0; i < DEPTH + 1; i++) rx_pulse(8'($urandom));
    status_check("rx_ovf_status", 32'hFFFF_FFFF, 32'h1);
    bus_rd(2'd1, r);
    check("rx_ovf_bit4", r & 32'h0000_FF10, 32'h0000_1010);
    bus_wr(2'd1, 32'h10);
    m_rxovr = 1'b0;
    status_check("rx_w1c", 32'hFFFF_FFFF, 32'h1);

    // Full RX FIFO, DATA read and rx_done in the same cycle.
    begin
      logic [7:0] d;
      logic [31:0] e;
      d = 8'($urandom);
      @(negedge clk);
      bus_cs = 1'b1; bus_we = 1'b0; bus_addr = 2'd0;
      uart_rx_done = 1'b1; uart_data_out = d;
      @(negedge clk);
      bus_cs = 1'b0; uart_rx_done = 1'b0;
      e = {24'h0, rxq.pop_front()};
      rxq.push_back(d);
      check("full_rdpush_data", bus_rdata, e);
    end
    bus_rd(2'd1, r);
    check("full_rdpush_status", r & 32'h0000_FF18, 32'h0000_1008);

    for (int i = 0; i < DEPTH; i++) data_read_check("rx_drain");
    status_check("rx_drained", 32'hFFFF_FFFF, 32'h1);

    // Interrupt on RX data.
    bus_wr(2'd2, 32'h3);
    bus_rd(2'd2, r);
    check("ctrl_rb", r, IRQ_ON ? 32'h3 : 32'h1);
    rx_pulse(8'($urandom));
    @(negedge clk);
    check("irq_rx_set", 32'(irq), 32'(IRQ_ON));
    data_read_check("irq_rx_data");
    @(negedge clk);
    check("irq_rx_clr", 32'(irq), 32'h0);
    bus_wr(2'd2, 32'h1);

    // TX overflow with EN clear (nothing drains).
    bus_wr(2'd2, 32'h0);
    for (int i = 0; i < DEPTH + 2; i++) data_write(8'($urandom), i < DEPTH);
    status_check("tx_ovf_status", 32'hFFFF_FFFF, 32'h0010_0002);
    bus_wr(2'd1, 32'h20);
    m_txovr = 1'b0;
    status_check("tx_w1c", 32'hFFFF_FFFF, 32'h0010_0002);
    bus_wr(2'd2, 32'h1);
    drain_tx("tx_ovf");

    // Randomised mix.
    rand_busy = 1'b1;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rx_pulse(8'($urandom));
        3, 4:    data_read_check("rnd_data");
        5:       status_check("rnd_status", 32'h0000_FF3C, 32'h0);
        6:       if (exp_tx.size() - sent_q.size() < 8) data_write(8'($urandom), 1'b1);
        7:       begin
                   bus_wr(2'd1, 32'h10);
                   m_rxovr = 1'b0;
                 end
        8:       begin
                   bus_wr(2'd3, $urandom);
                   bus_rd(2'd3, r);
                   check("rnd_reserved", r, 32'h0);
                 end
        default: begin
                   bus_rd(2'd2, r);
                   check("rnd_ctrl", r, 32'h1);
                 end
      endcase
    end
    drain_tx("rnd");
    status_check("rnd_final", 32'hFFFF_FFFF, 32'h1);
    check("we_vs_busy", 32'(we_busy_viol), 32'h0);

    // Async reset while a request is pending.
    core_on = 1'b0;
    data_write(8'h99, 1'b1);
    t = 0;
    while (!uart_we && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mid_req_we", 32'(uart_we), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(uart_we), 32'h0);
    check("mid_rst_data_in", 32'(uart_data_in), 32'h0);
    rxq.delete();
    m_rxovr = 1'b0;
    m_txovr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd(2'd1, r);
    check("post_rst_status", r, 32'h5);
    bus_rd(2'd2, r);
    check("post_rst_ctrl", r, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
